reg_wb_queue: RTL and testbench

Writeback queue sitting between the execution units and the register file's write port C. It buffers up to DEPTH results, drains one write per cycle onto `addr_c`/`regport_c`/`write_regc`, and yields to port-A reads, since in the RAM build port A and port C share one RAM address. It also provides a two-port bypass lookup, so operand fetch sees results that are still queued and not yet in the register file.

---
 rtl/reg_wb_queue.sv | 97 +++++++++
 tb/tb_reg_wb_queue.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_queue.sv
// Writeback queue in front of register file port C: buffers results, drains one per
// cycle when port A is idle, and offers a two-port bypass of still-queued results.
module reg_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wb_valid,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     wb_ready,
    input  logic                     rd_a_busy,
    output logic [ADDR_W-1:0]        addr_c,
    output logic [DATA_W-1:0]        regport_c,
    output logic                     write_regc,
    input  logic [ADDR_W-1:0]        byp_addr_a,
    input  logic [ADDR_W-1:0]        byp_addr_b,
    output logic                     byp_hit_a,
    output logic                     byp_hit_b,
    output logic [DATA_W-1:0]        byp_data_a,
    output logic [DATA_W-1:0]        byp_data_b,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt_q;
    logic [PTR_W-1:0]  byp_idx;
    logic              push;
    logic              pop;
    logic              not_empty;

    // Ready deliberately ignores a same-cycle pop so rd_a_busy never reaches wb_ready.
    assign not_empty  = (cnt_q != '0);
    assign wb_ready   = reset_n && (cnt_q != FULL_CNT);
    assign write_regc = not_empty && !rd_a_busy;
    assign push       = wb_valid && wb_ready;
    assign pop        = write_regc;
    assign count      = cnt_q;
    assign addr_c     = not_empty ? addr_mem[rd_ptr] : '0;
    assign regport_c  = not_empty ? data_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Entry storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= wb_addr;
            data_mem[wr_ptr] <= wb_data;
        end
    end

    // Walk entries oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        byp_hit_a  = 1'b0;
        byp_hit_b  = 1'b0;
        byp_data_a = '0;
        byp_data_b = '0;
        byp_idx    = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            byp_idx = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < cnt_q) begin
                if (addr_mem[byp_idx] == byp_addr_a) begin
                    byp_hit_a  = 1'b1;
                    byp_data_a = data_mem[byp_idx];
                end
                if (addr_mem[byp_idx] == byp_addr_b) begin
                    byp_hit_b  = 1'b1;
                    byp_data_b = data_mem[byp_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: queue scoreboard checked every cycle, a bypass/latency
// vector table, and directed sequences for reset, full, stall and streaming cases.
module tb_reg_wb_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ready;
    logic              rd_a_busy;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] regport_c;
    logic              write_regc;
    logic [ADDR_W-1:0] byp_addr_a;
    logic [ADDR_W-1:0] byp_addr_b;
    logic              byp_hit_a;
    logic              byp_hit_b;
    logic [DATA_W-1:0] byp_data_a;
    logic [DATA_W-1:0] byp_data_b;
    logic [2:0]        count;

    reg_wb_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_n(reset_n), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_ready(wb_ready), .rd_a_busy(rd_a_busy),
        .addr_c(addr_c), .regport_c(regport_c), .write_regc(write_regc),
        .byp_addr_a(byp_addr_a), .byp_addr_b(byp_addr_b),
        .byp_hit_a(byp_hit_a), .byp_hit_b(byp_hit_b),
        .byp_data_a(byp_data_a), .byp_data_b(byp_data_b), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    typedef struct {
        bit                rn;
        bit                v;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        bit                busy;
        logic [ADDR_W-1:0] ba;
        logic [ADDR_W-1:0] bb;
        int                e_cnt;
        bit                e_wrc;
        bit                e_ha;
        logic [DATA_W-1:0] e_da;
        bit                e_hb;
        logic [DATA_W-1:0] e_db;
    } vec_t;

    ent_t sb[$];
    vec_t vecs[12];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   n_writes = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual %0h required %0h", nm, $time, act, exp);
        end
    endtask

    // One cycle: compare all outputs against the queue model, then advance it at the edge.
    task automatic tick(output bit acc);
        int   n;
        bit   exp_wrc, exp_rdy, eh_a, eh_b;
        logic [DATA_W-1:0] ed_a, ed_b;
        ent_t h, e;
        #2;
        n       = sb.size();
        exp_wrc = (n != 0) && !rd_a_busy;
        exp_rdy = reset_n && (n != DEPTH);
        h       = (n != 0) ? sb[0] : '0;
        eh_a = 1'b0; ed_a = '0; eh_b = 1'b0; ed_b = '0;
        for (int i = 0; i < n; i++) begin
            if (sb[i].a == byp_addr_a) begin eh_a = 1'b1; ed_a = sb[i].d; end
            if (sb[i].a == byp_addr_b) begin eh_b = 1'b1; ed_b = sb[i].d; end
        end
        check("count", 64'(count), 64'(n));
        check("wb_ready", 64'(wb_ready), 64'(exp_rdy));
        check("write_regc", 64'(write_regc), 64'(exp_wrc));
        check("addr_c", 64'(addr_c), 64'(h.a));
        check("regport_c", regport_c, h.d);
        check("byp_hit_a", 64'(byp_hit_a), 64'(eh_a));
        check("byp_data_a", byp_data_a, ed_a);
        check("byp_hit_b", 64'(byp_hit_b), 64'(eh_b));
        check("byp_data_b", byp_data_b, ed_b);
        acc = wb_valid && exp_rdy;
        e.a = wb_addr;
        e.d = wb_data;
        @(posedge clk);
        if (!reset_n) begin
            sb.delete();
        end else begin
            if (exp_wrc) begin
                h = sb.pop_front();
                n_writes++;
            end
            if (acc) sb.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        int idx, w0;

        vecs[0]  = '{1, 1, 9, 'hA,  1, 9, 4, 0, 0, 0, 0,     0, 0};
        vecs[1]  = '{1, 1, 3, 'hB,  1, 9, 4, 1, 0, 1, 'hA,   0, 0};
        vecs[2]  = '{1, 1, 9, 'hC,  1, 9, 4, 2, 0, 1, 'hA,   0, 0};
        vecs[3]  = '{1, 0, 0, 0,    1, 9, 4, 3, 0, 1, 'hC,   0, 0};
        vecs[4]  = '{1, 0, 0, 0,    1, 3, 9, 3, 0, 1, 'hB,   1, 'hC};
        vecs[5]  = '{1, 0, 0, 0,    0, 9, 3, 3, 1, 1, 'hC,   1, 'hB};
        vecs[6]  = '{1, 0, 0, 0,    0, 9, 3, 2, 1, 1, 'hC,   1, 'hB};
        vecs[7]  = '{1, 0, 0, 0,    0, 9, 3, 1, 1, 1, 'hC,   0, 0};
        vecs[8]  = '{1, 0, 0, 0,    0, 9, 3, 0, 0, 0, 0,     0, 0};
        vecs[9]  = '{1, 1, 0, 'h77, 0, 0, 3, 0, 0, 0, 0,     0, 0};
        vecs[10] = '{1, 0, 0, 0,    0, 0, 3, 1, 1, 1, 'h77,  0, 0};
        vecs[11] = '{1, 0, 0, 0,    0, 0, 3, 0, 0, 0, 0,     0, 0};

        reset_n = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        rd_a_busy = 1'b0; byp_addr_a = '0; byp_addr_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset with three entries queued
        rd_a_busy = 1'b1; byp_addr_a = 7'd10; byp_addr_b = 7'd11;
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1'b1; wb_addr = ADDR_W'(10 + i); wb_data = 64'(100 + i);
            tick(acc);
        end
        rd_a_busy = 1'b0; reset_n = 1'b0; wb_addr = 7'd10;
        #1 check("ready_in_reset", 64'(wb_ready), 64'd0);
        tick(acc);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_wrc", 64'(write_regc), 64'd0);
        check("rst_hit_a", 64'(byp_hit_a), 64'd0);
        check("rst_ready", 64'(wb_ready), 64'd0);
        tick(acc);
        reset_n = 1'b1; wb_valid = 1'b0;
        #1 check("ready_after_reset", 64'(wb_ready), 64'd1);
        tick(acc);

        // Single push latency
        wb_valid = 1'b1; wb_addr = 7'd5; wb_data = 64'h1111;
        tick(acc);
        wb_valid = 1'b0;
        #1;
        check("lat_wrc", 64'(write_regc), 64'd1);
        check("lat_addr", 64'(addr_c), 64'd5);
        check("lat_data", regport_c, 64'h1111);
        tick(acc);
        #1 check("lat_drained", 64'(count), 64'd0);
        tick(acc);

        // Bypass table
        for (int i = 0; i < 12; i++) begin
            reset_n = vecs[i].rn; wb_valid = vecs[i].v; wb_addr = vecs[i].a;
            wb_data = vecs[i].d; rd_a_busy = vecs[i].busy;
            byp_addr_a = vecs[i].ba; byp_addr_b = vecs[i].bb;
            #1;
            check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
            check($sformatf("vec%0d_wrc", i), 64'(write_regc), 64'(vecs[i].e_wrc));
            check($sformatf("vec%0d_hit_a", i), 64'(byp_hit_a), 64'(vecs[i].e_ha));
            check($sformatf("vec%0d_data_a", i), byp_data_a, vecs[i].e_da);
            check($sformatf("vec%0d_hit_b", i), 64'(byp_hit_b), 64'(vecs[i].e_hb));
            check($sformatf("vec%0d_data_b", i), byp_data_b, vecs[i].e_db);
            tick(acc);
        end

        // Stall with five offers, then release
        rd_a_busy = 1'b1; idx = 0; w0 = n_writes;
        for (int c = 0; c < 8; c++) begin
            wb_valid = 1'b1; wb_addr = ADDR_W'(20 + idx); wb_data = 64'(16'hD000 + idx);
            tick(acc);
            if (acc) idx++;
        end
        #1;
        check("stall_count", 64'(count), 64'd4);
        check("stall_ready", 64'(wb_ready), 64'd0);
        rd_a_busy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            wb_valid = (idx < 5);
            wb_addr = ADDR_W'(20 + idx); wb_data = 64'(16'hD000 + idx);
            tick(acc);
            if (acc) idx++;
        end
        check("stall_writes", 64'(n_writes - w0), 64'd5);
        check("stall_empty", 64'(count), 64'd0);

        // Full queue: pop and offer in one cycle -> count 4,3,4
        rd_a_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1'b1; wb_addr = ADDR_W'(30 + i); wb_data = 64'(i + 1);
            tick(acc);
        end
        wb_addr = 7'd34; wb_data = 64'h55; rd_a_busy = 1'b0;
        #1;
        check("full_count_0", 64'(count), 64'd4);
        check("full_ready_0", 64'(wb_ready), 64'd0);
        tick(acc);
        rd_a_busy = 1'b1;
        #1;
        check("full_count_1", 64'(count), 64'd3);
        check("full_ready_1", 64'(wb_ready), 64'd1);
        tick(acc);
        wb_valid = 1'b0;
        #1 check("full_count_2", 64'(count), 64'd4);
        tick(acc);
        rd_a_busy = 1'b0;
        repeat (5) tick(acc);

        // Streaming with pointer wrap
        w0 = n_writes;
        for (int i = 0; i < 20; i++) begin
            wb_valid = 1'b1; wb_addr = ADDR_W'(40 + i); wb_data = 64'(i * 3 + 1);
            byp_addr_a = ADDR_W'(39 + i); byp_addr_b = ADDR_W'(40 + i);
            #1 check($sformatf("stream_count%0d", i), 64'(count), (i == 0) ? 64'd0 : 64'd1);
            tick(acc);
        end
        wb_valid = 1'b0;
        tick(acc);
        check("stream_writes", 64'(n_writes - w0), 64'd20);
        check("stream_empty", 64'(count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
